// File: rtl/tx_flex_counter_v2_if.sv
// tx_flex_counter_v2_if: control/status bundle for tx_flex_counter_v2; wrap_count exists only with TX_WRAP_CNT_EN
interface tx_flex_counter_v2_if #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int WRAP_CNT_BITS = 8
);
  logic                     clear;
  logic                     load;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic                     count_enable;
  logic                     stall;
  logic                     dir;
  logic                     one_shot;
  logic [NUM_CNT_BITS-1:0]  rollover_val;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     rollover_flag;
  logic                     wrap_pulse;
  logic                     done;
`ifdef TX_WRAP_CNT_EN
  logic [WRAP_CNT_BITS-1:0] wrap_count;
  modport master (
    output clear, load, load_val, count_enable, stall, dir, one_shot, rollover_val,
    input  count_out, rollover_flag, wrap_pulse, done, wrap_count
  );
  modport slave (
    input  clear, load, load_val, count_enable, stall, dir, one_shot, rollover_val,
    output count_out, rollover_flag, wrap_pulse, done, wrap_count
  );
`else
  modport master (
    output clear, load, load_val, count_enable, stall, dir, one_shot, rollover_val,
    input  count_out, rollover_flag, wrap_pulse, done
  );
  modport slave (
    input  clear, load, load_val, count_enable, stall, dir, one_shot, rollover_val,
    output count_out, rollover_flag, wrap_pulse, done
  );
`endif
endinterface

// File: rtl/tx_flex_counter_v2.sv
// tx_flex_counter_v2: up/down flex counter with load, stall, one-shot and wrap pulse; TX_WRAP_CNT_EN adds a saturating wrap_count
module tx_flex_counter_v2 #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int START_VAL     = 1,
  parameter int WRAP_CNT_BITS = 8
) (
  input logic                 clk,
  input logic                 n_rst,
  tx_flex_counter_v2_if.slave bus
);
  localparam logic [NUM_CNT_BITS-1:0] S = NUM_CNT_BITS'(START_VAL);
  logic [NUM_CNT_BITS-1:0] term, step, cnt_nxt;
  logic wrap, hold, ctl, done_nxt, pulse_nxt, flag_nxt;
  always_comb begin
    term      = bus.dir ? S : bus.rollover_val;
    wrap      = bus.dir ? bus.count_out == S : bus.count_out >= bus.rollover_val;
    hold      = bus.stall || !bus.count_enable || bus.done;
    ctl       = bus.clear || bus.load;
    // down mode reloads from below START_VAL or above rollover_val, but only START_VAL counts as a wrap
    step      = bus.dir ? ((bus.count_out <= S || bus.count_out > bus.rollover_val) ? bus.rollover_val : bus.count_out - 1'b1)
                        : (wrap ? S : bus.count_out + 1'b1);
    cnt_nxt   = bus.clear ? '0 : bus.load ? bus.load_val : hold ? bus.count_out : (wrap && bus.one_shot) ? term : step;
    done_nxt  = !ctl && (bus.done || (!hold && wrap && bus.one_shot));
    pulse_nxt = !ctl && !hold && wrap;
    flag_nxt  = cnt_nxt == term;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bus.count_out     <= '0;
      bus.rollover_flag <= 1'b0;
      bus.wrap_pulse    <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      bus.count_out     <= cnt_nxt;
      bus.rollover_flag <= flag_nxt;
      bus.wrap_pulse    <= pulse_nxt;
      bus.done          <= done_nxt;
    end
  end
`ifdef TX_WRAP_CNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst || bus.clear) bus.wrap_count <= '0;
    else if (pulse_nxt && bus.wrap_count != '1) bus.wrap_count <= bus.wrap_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_tx_flex_counter_v2.sv
// tb_tx_flex_counter_v2: directed self-checking bench for tx_flex_counter_v2 (START_VAL=1, 4-bit count)
module tb_tx_flex_counter_v2;
  logic clk = 1'b0;
  logic n_rst;
  int n_chk = 0;
  int n_fail = 0;
  tx_flex_counter_v2_if #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(2)) bus ();
  tx_flex_counter_v2 #(.NUM_CNT_BITS(4), .START_VAL(1), .WRAP_CNT_BITS(2)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_out(string tag, int c, bit f, bit p, bit d);
    logic [3:0] cv;
    cv = 4'(c);
    chk(tag, {25'd0, bus.count_out, bus.rollover_flag, bus.wrap_pulse, bus.done}, {25'd0, cv, f, p, d});
  endtask
  initial begin
    int up_c[6] = '{1, 2, 3, 4, 1, 2};
    bit up_f[6] = '{0, 0, 0, 1, 0, 0};
    bit up_p[6] = '{0, 0, 0, 0, 1, 0};
    int dn_c[4] = '{2, 1, 6, 5};
    bit dn_f[4] = '{0, 1, 0, 0};
    bit dn_p[4] = '{0, 0, 1, 0};
    n_rst = 1'b0;
    bus.clear = 0; bus.load = 0; bus.load_val = 0; bus.stall = 0;
    bus.dir = 0; bus.one_shot = 0; bus.rollover_val = 4; bus.count_enable = 1;
    tick();
    expect_out("reset", 0, 0, 0, 0);
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_out($sformatf("up[%0d]", i), up_c[i], up_f[i], up_p[i], 0);
    end
    bus.rollover_val = 8; bus.load = 1; bus.load_val = 5;
    tick();
    expect_out("stall_load", 5, 0, 0, 0);
    bus.load = 0; bus.stall = 1;
    tick();
    expect_out("stall1", 5, 0, 0, 0);
    tick();
    expect_out("stall2", 5, 0, 0, 0);
    bus.stall = 0;
    tick();
    expect_out("stall_release", 6, 0, 0, 0);
    bus.count_enable = 0;
    tick();
    expect_out("disabled", 6, 0, 0, 0);
    bus.count_enable = 1; bus.dir = 1; bus.rollover_val = 6; bus.load = 1; bus.load_val = 3;
    tick();
    expect_out("down_load", 3, 0, 0, 0);
    bus.load = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("down[%0d]", i), dn_c[i], dn_f[i], dn_p[i], 0);
    end
    bus.dir = 0; bus.rollover_val = 3; bus.one_shot = 1; bus.clear = 1;
    tick();
    expect_out("os_clear", 0, 0, 0, 0);
    bus.clear = 0;
    tick(); expect_out("os1", 1, 0, 0, 0);
    tick(); expect_out("os2", 2, 0, 0, 0);
    tick(); expect_out("os3", 3, 1, 0, 0);
    tick(); expect_out("os_done", 3, 1, 1, 1);
    tick(); expect_out("os_hold1", 3, 1, 0, 1);
    tick(); expect_out("os_hold2", 3, 1, 0, 1);
    bus.load = 1; bus.load_val = 0;
    tick(); expect_out("os_reload", 0, 0, 0, 0);
    bus.load = 0;
    tick(); expect_out("os_resume", 1, 0, 0, 0);
    bus.one_shot = 0; bus.clear = 1; bus.load = 1; bus.load_val = 7; bus.stall = 1;
    tick(); expect_out("simul_ctl", 0, 0, 0, 0);
    bus.clear = 0; bus.load = 0; bus.stall = 0;
    tick(); expect_out("post_simul1", 1, 0, 0, 0);
    tick(); expect_out("post_simul2", 2, 0, 0, 0);
    n_rst = 1'b0;
    #3;
    expect_out("rst_no_async", 2, 0, 0, 0);
    tick(); expect_out("rst_mid", 0, 0, 0, 0);
    n_rst = 1'b1; bus.rollover_val = 1;
    tick(); expect_out("eq_start0", 1, 1, 0, 0);
    tick(); expect_out("eq_start1", 1, 1, 1, 0);
    bus.dir = 1;
    tick(); expect_out("eq_start_dn", 1, 1, 1, 0);
    bus.dir = 0; bus.rollover_val = 8; bus.load = 1; bus.load_val = 7;
    tick(); expect_out("oor_load", 7, 0, 0, 0);
    bus.load = 0; bus.rollover_val = 3;
    tick(); expect_out("oor_up", 1, 0, 1, 0);
    bus.load = 1; bus.load_val = 7; bus.dir = 1;
    tick(); expect_out("oor_dn_load", 7, 0, 0, 0);
    bus.load = 0;
    tick(); expect_out("oor_dn", 3, 0, 0, 0);
    bus.load = 1; bus.load_val = 0; bus.rollover_val = 5;
    tick(); expect_out("below_start_load", 0, 0, 0, 0);
    bus.load = 0;
    tick(); expect_out("below_start_dn", 5, 0, 0, 0);
`ifdef TX_WRAP_CNT_EN
    bus.dir = 0; bus.rollover_val = 1; bus.clear = 1;
    tick(); chk("wc_clear0", 32'(bus.wrap_count), 0);
    bus.clear = 0;
    tick(); chk("wc_nowrap", 32'(bus.wrap_count), 0);
    tick(); chk("wc1", 32'(bus.wrap_count), 1);
    tick(); chk("wc2", 32'(bus.wrap_count), 2);
    tick(); chk("wc3", 32'(bus.wrap_count), 3);
    tick(); chk("wc_sat", 32'(bus.wrap_count), 3);
    bus.load = 1; bus.load_val = 0;
    tick(); chk("wc_load", 32'(bus.wrap_count), 3);
    bus.load = 0; bus.clear = 1;
    tick(); chk("wc_clear", 32'(bus.wrap_count), 0);
    bus.clear = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_flex_counter_v2.md
Name: tx_flex_counter_v2

Overview:
- Parametrised successor to the TX-side flex counter, used for bit-period timing, bit-in-byte counting and byte counting in the USB TX path.
- Adds the following over the current counter:
  - up/down direction
  - programmable wrap-start value
  - parallel load
  - stall input (bit-stuff hold) with priority separate from enable
  - one-shot (halt-at-terminal) mode
  - single-cycle wrap pulse
- Sits beside the TX FSM; one instance per timing level.

Parameters:
- NUM_CNT_BITS, 4, width of count, rollover and load values.
- START_VAL, 1, value the counter wraps to in up mode and terminates at in down mode (must be < 2^NUM_CNT_BITS).
- WRAP_CNT_BITS, 8, width of wrap_count (used only with TX_WRAP_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous clear of count and status.
- load  in  1  parallel load strobe.
- load_val  in  NUM_CNT_BITS  value loaded when load=1.
- count_enable  in  1  advance counter when 1.
- stall  in  1  hold counter this cycle (bit-stuff insertion); overrides count_enable.
- dir  in  1  0 = count up, 1 = count down.
- one_shot  in  1  1 = halt at terminal value instead of wrapping.
- rollover_val  in  NUM_CNT_BITS  upper bound of count range.
- count_out  out  NUM_CNT_BITS  current count, registered.
- rollover_flag  out  1  high while count_out equals the terminal value, registered.
- wrap_pulse  out  1  one-cycle pulse on each wrap, registered.
- done  out  1  sticky one-shot completion, registered.

Behaviour:
- Reset: all state is sampled on the rising clk edge when n_rst=0 (synchronous, active-low). The reset values are count_out=0, rollover_flag=0, wrap_pulse=0, done=0.
- Priority per cycle, highest first: n_rst, clear, load, stall, !count_enable, done hold, count.
- clear:
  - count_out=0, done=0, wrap_pulse=0.
  - rollover_flag is recomputed from the new value.
- load:
  - count_out=load_val, done=0, wrap_pulse=0.
  - load_val is taken as-is, even outside the range.
- stall=1 or count_enable=0: count_out and done hold; wrap_pulse=0.
- done=1: count_out holds until clear or load, even if enabled.
- Terminal value T: T=rollover_val when dir=0; T=START_VAL when dir=1.
- Up count (dir=0):
  - If count_out >= rollover_val, next=START_VAL and this is a wrap.
  - Otherwise next=count_out+1.
  - From reset, the sequence is 0,1,2..R,S,S+1..R.
- Down count (dir=1):
  - If count_out <= START_VAL or count_out > rollover_val, next=rollover_val. This is a wrap only when count_out==START_VAL.
  - Otherwise next=count_out-1.
- One-shot (one_shot=1): on a cycle where a wrap would occur, count_out holds at T, done<=1 and wrap_pulse<=1. No further counting.
- rollover_flag is registered from next-state: it equals (next count_out == next T). It is therefore exactly coincident with count_out==T, with no one-cycle lag.
- wrap_pulse: high for exactly the one cycle after a counting wrap, coincident with count_out==START_VAL (up) or rollover_val (down). It never asserts on clear or load.
- rollover_val or dir changes mid-count:
  - The new compare applies on the next edge.
  - An out-of-range count takes the wrap/reload rule above; no lockup.
- rollover_val==START_VAL: count stays at START_VAL, rollover_flag=1, and wrap_pulse=1 on every enabled cycle.
- Arithmetic is unsigned, NUM_CNT_BITS wide. No carry out beyond the wrap rules.
- Reset asserted mid-count or mid-one-shot overrides everything on that edge.

Optional Feature:
- Macro: TX_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_count [WRAP_CNT_BITS-1:0] with reset value 0.
  - Increments on each cycle wrap_pulse is set, saturating at all-ones.
  - Cleared by clear; unaffected by load.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then up count (n_rst=0 one cycle; dir=0, rollover_val=4, count_enable=1) -> count_out 0,1,2,3,4,1,2...; rollover_flag high only while count_out=4; wrap_pulse high on the cycles count_out returns to 1.
- Stall (up count, R=8, stall=1 for 2 cycles at count_out=5 with count_enable=1) -> count_out stays 5 for 2 extra cycles, then 6; no wrap_pulse.
- Down count with load (dir=1, R=6, load=1 with load_val=3) -> 3,2,1,6,5...; wrap_pulse on the cycle count_out=6; rollover_flag while count_out=1.
- One-shot (one_shot=1, dir=0, R=3, from clear) -> 0,1,2,3 then holds 3; done=1 and stays; wrap_pulse one cycle; load_val=0 with load=1 -> done=0, counting resumes.
- Simultaneous controls (clear=1, load=1, stall=1 in the same cycle) -> count_out=0. Then synchronous reset asserted mid-count -> all outputs 0 on that edge, with no async effect between edges.
- With TX_WRAP_CNT_EN and WRAP_CNT_BITS=2, R=1 -> wrap_count 1,2,3,3 (saturates); clear -> 0.
